// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
// Optional signed-overflow output is enabled with SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;

   modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/bit_full_adder.sv
// One-bit combinational full adder driven by serial_adder.
module bit_full_adder (
   input  logic inA,
   input  logic inB,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = inA ^ inB ^ cin;
   assign cout = (inA & inB) | (cin & (inA ^ inB));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder step per clock, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   serial_adder_if.slave bus
);

   localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

   state_e           r_state, w_state_d;
   logic [WIDTH-1:0] r_sh_a, w_sh_a_d;
   logic [WIDTH-1:0] r_sh_b, w_sh_b_d;
   logic [WIDTH-1:0] r_sum, w_sum_d;
   // Only the upper WIDTH-1 result bits are ever needed again.
   logic [WIDTH-2:0] r_res, w_res_d;
   logic [CntW-1:0]  r_cnt, w_cnt_d;
   logic             r_carry, w_carry_d;
   logic             r_cout, w_cout_d;
   logic             w_fa_sum, w_fa_cout;
   logic [WIDTH-1:0] w_res_full;
`ifdef SERIAL_ADDER_OVF_EN
   logic             r_ovf, w_ovf_d;
`endif

   bit_full_adder u_fa (
      .inA  (r_sh_a[0]),
      .inB  (r_sh_b[0]),
      .cin  (r_carry),
      .sum  (w_fa_sum),
      .cout (w_fa_cout)
   );

   assign w_res_full = {w_fa_sum, r_res};

   always_comb begin
      w_state_d = r_state;
      w_sh_a_d  = r_sh_a;
      w_sh_b_d  = r_sh_b;
      w_res_d   = r_res;
      w_cnt_d   = r_cnt;
      w_carry_d = r_carry;
      w_sum_d   = r_sum;
      w_cout_d  = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
      w_ovf_d   = r_ovf;
`endif
      unique case (r_state)
         IDLE, DONE: begin
            if (bus.start) begin
               w_sh_a_d  = bus.a;
               w_sh_b_d  = bus.b;
               w_carry_d = bus.cin;
               w_cnt_d   = '0;
               w_res_d   = '0;
               w_state_d = SHIFT;
            end else begin
               w_state_d = IDLE;
            end
         end
         SHIFT: begin
            w_sh_a_d  = r_sh_a >> 1;
            w_sh_b_d  = r_sh_b >> 1;
            w_res_d   = w_res_full[WIDTH-1:1];
            w_carry_d = w_fa_cout;
            w_cnt_d   = r_cnt + CntW'(1);
            if (r_cnt == CntLast) begin
               w_sum_d   = w_res_full;
               w_cout_d  = w_fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
               // r_carry is the carry into the MSB on the final step.
               w_ovf_d   = r_carry ^ w_fa_cout;
`endif
               w_state_d = DONE;
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_sh_a  <= '0;
         r_sh_b  <= '0;
         r_res   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= 1'b0;
`endif
      end else begin
         r_state <= w_state_d;
         r_sh_a  <= w_sh_a_d;
         r_sh_b  <= w_sh_b_d;
         r_res   <= w_res_d;
         r_cnt   <= w_cnt_d;
         r_carry <= w_carry_d;
         r_sum   <= w_sum_d;
         r_cout  <= w_cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         r_ovf   <= w_ovf_d;
`endif
      end
   end

   assign bus.busy = (r_state == SHIFT);
   assign bus.done = (r_state == DONE);
   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: vector table, random ops, corner sequences.
// Overflow checks are compiled in with SERIAL_ADDER_OVF_EN.
module tb_serial_adder;

   localparam int unsigned W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin);
      int unsigned s;
      s = int'(a) + int'(b) + int'(cin);
      return (W+1)'(s);
   endfunction

   function automatic logic model_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin);
      int sa;
      int sb;
      int s;
      sa = (a >= 128) ? int'(a) - 256 : int'(a);
      sb = (b >= 128) ? int'(b) - 256 : int'(b);
      s  = sa + sb + int'(cin);
      return (s > 127) || (s < -128);
   endfunction

   // One complete operation: pulse start, watch busy/done, check the result and its hold.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                         input logic [W-1:0] es, input logic ec, input logic eo,
                         input string name);
      int           busy_n;
      int           done_n;
      int           done_at;
      logic [W-1:0] got_s;
      logic         got_c;
`ifdef SERIAL_ADDER_OVF_EN
      logic         got_o;
      got_o = 1'bx;
`endif
      busy_n  = 0;
      done_n  = 0;
      done_at = 0;
      got_s   = 'x;
      got_c   = 1'bx;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      bus.cin   = cv;
      for (int i = 1; i <= int'(W) + 4; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus.start = 1'b0;
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.cin   = 1'($urandom);
         end
         if (bus.busy === 1'b1) busy_n++;
         if (bus.done === 1'b1) begin
            done_n++;
            done_at = i;
            got_s   = bus.sum;
            got_c   = bus.cout;
`ifdef SERIAL_ADDER_OVF_EN
            got_o   = bus.ovf;
`endif
         end
      end
      check({name, ".sum"}, 32'(got_s), 32'(es));
      check({name, ".cout"}, 32'(got_c), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
      check({name, ".ovf"}, 32'(got_o), 32'(eo));
`else
      if (eo !== 1'b0 && eo !== 1'b1) $display("note: %s ovf undefined", name);
`endif
      check({name, ".done_cycle"}, 32'(done_at), 32'(W + 1));
      check({name, ".done_count"}, 32'(done_n), 32'd1);
      check({name, ".busy_cycles"}, 32'(busy_n), 32'(W));
      check({name, ".sum_held"}, 32'(bus.sum), 32'(es));
   endtask

   vec_t vecs[6];

   initial begin
      logic [W:0]   m;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      int           done_n;
      int           done_at;
      int           done_at2;
      logic [W-1:0] s1;
      logic [W-1:0] s2;

      vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, exp_sum: 8'h10, exp_cout: 1'b0, exp_ovf: 1'b0};
      vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1, exp_ovf: 1'b0};
      vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, exp_sum: 8'hFF, exp_cout: 1'b1, exp_ovf: 1'b0};
      vecs[3] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, exp_sum: 8'h80, exp_cout: 1'b0, exp_ovf: 1'b1};
      vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, exp_sum: 8'h00, exp_cout: 1'b1, exp_ovf: 1'b1};
      vecs[5] = '{a: 8'h00, b: 8'h00, cin: 1'b1, exp_sum: 8'h01, exp_cout: 1'b0, exp_ovf: 1'b0};

      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (3) @(negedge clk);
      check("reset.busy", 32'(bus.busy), 32'd0);
      check("reset.done", 32'(bus.done), 32'd0);
      check("reset.sum", 32'(bus.sum), 32'd0);
      check("reset.cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("reset.ovf", 32'(bus.ovf), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      check("idle.busy", 32'(bus.busy), 32'd0);

      for (int i = 0; i < 6; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
                vecs[i].exp_ovf, $sformatf("vec%0d", i));
      end

      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         m  = model_add(ra, rb, rc);
         run_op(ra, rb, rc, m[W-1:0], m[W], model_ovf(ra, rb, rc), $sformatf("rand%0d", i));
      end

      // start re-pulsed mid-SHIFT must be ignored
      done_n  = 0;
      done_at = 0;
      s1      = 'x;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h12;
      bus.b     = 8'h34;
      bus.cin   = 1'b0;
      for (int i = 1; i <= 2 * int'(W) + 4; i++) begin
         @(negedge clk);
         bus.start = (i == 3);
         if (i == 3) begin
            bus.a = 8'hAA;
            bus.b = 8'h55;
         end
         if (bus.done === 1'b1) begin
            done_n++;
            done_at = i;
            s1      = bus.sum;
         end
      end
      check("restart.sum", 32'(s1), 32'h46);
      check("restart.done_cycle", 32'(done_at), 32'(W + 1));
      check("restart.done_count", 32'(done_n), 32'd1);

      // synchronous reset in the middle of SHIFT
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'hF0;
      bus.b     = 8'h1F;
      bus.cin   = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      check("abort.busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort.busy", 32'(bus.busy), 32'd0);
      check("abort.done", 32'(bus.done), 32'd0);
      check("abort.sum", 32'(bus.sum), 32'd0);
      check("abort.cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("abort.ovf", 32'(bus.ovf), 32'd0);
`endif
      done_n = 0;
      for (int i = 0; i < int'(W) + 2; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.busy === 1'b1) done_n++;
      end
      check("abort.quiet", 32'(done_n), 32'd0);
      m = model_add(8'h3C, 8'h41, 1'b1);
      run_op(8'h3C, 8'h41, 1'b1, m[W-1:0], m[W], model_ovf(8'h3C, 8'h41, 1'b1), "after_abort");

      // start held high: back-to-back operations
      done_n   = 0;
      done_at  = 0;
      done_at2 = 0;
      s1       = 'x;
      s2       = 'x;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h01;
      bus.b     = 8'h02;
      bus.cin   = 1'b0;
      for (int i = 1; i <= 3 * int'(W); i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus.a = 8'h10;
            bus.b = 8'h20;
         end
         if (bus.done === 1'b1) begin
            done_n++;
            if (done_n == 1) begin
               done_at = i;
               s1      = bus.sum;
            end else begin
               done_at2 = i;
               s2       = bus.sum;
               bus.start = 1'b0;
            end
         end
      end
      bus.start = 1'b0;
      check("b2b.first_sum", 32'(s1), 32'h03);
      check("b2b.second_sum", 32'(s2), 32'h30);
      check("b2b.first_done", 32'(done_at), 32'(W + 1));
      check("b2b.spacing", 32'(done_at2 - done_at), 32'(W + 1));
      check("b2b.done_count", 32'(done_n), 32'd2);
      check("b2b.idle_busy", 32'(bus.busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
